// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolve unit: branch funct3 encodings,
// the 2-bit BHT counter encoding and its saturating update helper.
package branch_resolve_unit_pkg;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } bht_cnt_t;

   // Saturating step of a 2-bit direction counter toward the resolved outcome.
   function automatic bht_cnt_t bht_next(input bht_cnt_t cnt, input logic taken);
      bht_cnt_t nxt;
      case (cnt)
         SNT:     nxt = taken ? WNT : SNT;
         WNT:     nxt = taken ? WT  : SNT;
         WT:      nxt = taken ? ST  : WNT;
         ST:      nxt = taken ? ST  : WT;
         default: nxt = WNT;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/branch_cmp.sv
// Combinational branch condition evaluator. Flags funct3 codes that are not
// branches so the caller can treat that cycle as idle.
module branch_cmp
   import branch_resolve_unit_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            taken,
   output logic            legal
);

   // Evaluate the full-width condition selected by funct3.
   always_comb begin
      taken = 1'b0;
      legal = 1'b1;
      case (funct3)
         F3_BEQ:  taken = (a == b);
         F3_BNE:  taken = (a != b);
         F3_BLT:  taken = ($signed(a) <  $signed(b));
         F3_BGE:  taken = ($signed(a) >= $signed(b));
         F3_BLTU: taken = (a <  b);
         F3_BGEU: taken = (a >= b);
         default: begin
            taken = 1'b0;
            legal = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: resolves execute-stage branches, trains a table of
// 2-bit saturating counters, predicts fetch-stage PCs and raises a one-cycle
// redirect on mispredict. Defining BRANCH_RESOLVE_STATS_EN adds resolve and
// mispredict counters on stat_branches / stat_mispredicts.
module branch_resolve_unit
   import branch_resolve_unit_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int BHT_DEPTH = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] if_pc,
   output logic            if_pred_taken,
   input  logic            ex_valid,
   input  logic            ex_kill,
   input  logic [2:0]      ex_funct3,
   input  logic [XLEN-1:0] ex_a,
   input  logic [XLEN-1:0] ex_b,
   input  logic [XLEN-1:0] ex_pc,
   input  logic [XLEN-1:0] ex_target,
   input  logic            ex_pred_taken,
   output logic            br_taken,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc
`ifdef BRANCH_RESOLVE_STATS_EN
   ,
   output logic [31:0]     stat_branches,
   output logic [31:0]     stat_mispredicts
`endif
);

   localparam int IDXW = $clog2(BHT_DEPTH);

   bht_cnt_t          bht [BHT_DEPTH];
   logic              cond_taken;
   logic              cond_legal;
   logic              resolve;
   logic              mispredict;
   logic [IDXW-1:0]   if_idx;
   logic [IDXW-1:0]   ex_idx;
   logic [XLEN-1:0]   next_pc;

   // Word-aligned PCs: the low two bits and the bits above the index never
   // take part in the lookup.
   logic unused_if_pc;
   assign unused_if_pc = ^{if_pc[XLEN-1:IDXW+2], if_pc[1:0]};

   branch_cmp #(.XLEN(XLEN)) u_cmp (
      .funct3 (ex_funct3),
      .a      (ex_a),
      .b      (ex_b),
      .taken  (cond_taken),
      .legal  (cond_legal)
   );

   // Resolve qualification, table indices, mispredict and correct next PC.
   always_comb begin
      if_idx     = if_pc[IDXW+1:2];
      ex_idx     = ex_pc[IDXW+1:2];
      resolve    = ex_valid & ~ex_kill & cond_legal;
      mispredict = resolve & (cond_taken ^ ex_pred_taken);
      if (cond_taken) begin
         next_pc = ex_target;
      end else begin
         next_pc = ex_pc + XLEN'(32'd4);
      end
   end

   // Prediction reads the table as it stands before this cycle's update.
   assign if_pred_taken = bht[if_idx][1];

   // Resolved direction, redirect pulse and redirect target registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         br_taken       <= 1'b0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
      end else begin
         redirect_valid <= mispredict;
         if (resolve) begin
            br_taken <= cond_taken;
         end
         if (mispredict) begin
            redirect_pc <= next_pc;
         end
      end
   end

   // Train the direction counter of the resolving branch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BHT_DEPTH; i++) begin
            bht[i] <= WNT;
         end
      end else if (resolve) begin
         bht[ex_idx] <= bht_next(bht[ex_idx], cond_taken);
      end
   end

`ifdef BRANCH_RESOLVE_STATS_EN
   // Free-running resolve and mispredict counters, wrapping at 2^32.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_branches    <= 32'd0;
         stat_mispredicts <= 32'd0;
      end else begin
         if (resolve) begin
            stat_branches <= stat_branches + 32'd1;
         end
         if (mispredict) begin
            stat_mispredicts <= stat_mispredicts + 32'd1;
         end
      end
   end
`endif

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 Parameter XLEN, default 32, operand/PC width (>= 32).
REQ-002 Parameter BHT_DEPTH, default 64, branch history table entries (power of two, >= 2); IDXW = log2(BHT_DEPTH).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 if_pc  input  XLEN  fetch-stage PC, used for prediction lookup.
REQ-006 if_pred_taken  output  1  prediction for if_pc, combinational.
REQ-007 ex_valid  input  1  execute-stage branch is present this cycle.
REQ-008 ex_kill  input  1  execute-stage instruction squashed; overrides ex_valid.
REQ-009 ex_funct3  input  3  branch funct3.
REQ-010 ex_a, ex_b  input  XLEN each  forwarded RS1/RS2 operands.
REQ-011 ex_pc, ex_target  input  XLEN each  branch PC and taken target.
REQ-012 ex_pred_taken  input  1  prediction carried down the pipe with this branch.
REQ-013 br_taken  output  1  registered resolved direction.
REQ-014 redirect_valid  output  1  registered one-cycle mispredict pulse.
REQ-015 redirect_pc  output  XLEN  registered correct next PC.

Function
REQ-016 Conditions: funct3 000 a==b; 001 a!=b; 100 signed a<b; 101 signed a>=b; 110 unsigned a<b; 111 unsigned a>=b; full XLEN width.
REQ-017 funct3 010/011 are illegal: not taken, no BHT update, no redirect, no statistics count.
REQ-018 A branch resolves when ex_valid=1, ex_kill=0 and funct3 is legal; otherwise the cycle is idle.
REQ-019 Latency one cycle: outputs in cycle N+1 reflect the branch resolved in cycle N.
REQ-020 Mispredict = taken XOR ex_pred_taken; redirect_valid=1 for exactly one cycle per mispredict, else 0.
REQ-021 redirect_pc = ex_target if taken, else ex_pc+4 modulo 2^XLEN; holds last value when redirect_valid=0.
REQ-022 br_taken updates only on resolve; holds otherwise.
REQ-023 BHT: BHT_DEPTH 2-bit saturating counters, index = pc[IDXW+1:2]; prediction = counter bit 1.
REQ-024 Update on resolve: taken increments, saturating at 11; not-taken decrements, saturating at 00.
REQ-025 Same-cycle lookup and update of same index: lookup returns pre-update value (no bypass).
REQ-026 Back-to-back resolves every cycle are supported with no stall.

Reset
REQ-027 rst_n low asynchronously forces: redirect_valid=0, br_taken=0, redirect_pc=0, all BHT counters=01 (weakly not-taken), statistics=0.
REQ-028 Reset asserted mid-operation drops any pending redirect; first resolve after release behaves as from cold start.

Configuration
REQ-029 Macro BRANCH_RESOLVE_STATS_EN defined: outputs stat_branches and stat_mispredicts (32 bits each) count resolves and mispredicts, wrapping at 2^32.
REQ-030 Macro undefined: those ports and counters are absent; all other behaviour is identical.

Structure
REQ-031 Shared package holds funct3 branch constants and counter encodings SNT=00, WNT=01, WT=10, ST=11.
REQ-032 Sub-module branch_cmp (combinational, XLEN-parametrised) computes the taken condition.

Verification
REQ-033 Reset release, BEQ a=5 b=5, pred 0, pc=0x100, target=0x200 -> next cycle redirect_valid=1, redirect_pc=0x200, br_taken=1.
REQ-034 BLT a=0xFFFFFFFF b=1, pred 1 -> no redirect; BLTU same operands, pred 1 -> redirect_pc=pc+4.
REQ-035 Three taken branches at pc=0x40 -> counter 01->10->11->11; if_pc=0x40 gives if_pred_taken=1.
REQ-036 funct3=010 or ex_kill=1 with ex_valid=1 -> no redirect, BHT and statistics unchanged.
REQ-037 Branch at pc=0xFFFFFFFC not taken, pred 1 -> redirect_pc=0x00000000.
REQ-038 rst_n low in the cycle after a mispredict resolves -> redirect_valid=0 immediately; BHT entries read 01.
